// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU opcode / condition-code encodings, execute-stage state type and
// divider timing constants.
package alu_exec_stage_pkg;

  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_MUL = 4'd2;
  localparam logic [3:0] ALU_OP_DIV = 4'd3;
  localparam logic [3:0] ALU_OP_MOD = 4'd4;
  localparam logic [3:0] ALU_OP_OR  = 4'd5;
  localparam logic [3:0] ALU_OP_XOR = 4'd6;
  localparam logic [3:0] ALU_OP_AND = 4'd7;
  localparam logic [3:0] ALU_OP_SHL = 4'd8;
  localparam logic [3:0] ALU_OP_SAR = 4'd9;

  localparam logic [3:0] ALU_CC_EQ    = 4'd0;
  localparam logic [3:0] ALU_CC_NE    = 4'd1;
  localparam logic [3:0] ALU_CC_L     = 4'd2;
  localparam logic [3:0] ALU_CC_LE    = 4'd3;
  localparam logic [3:0] ALU_CC_G     = 4'd4;
  localparam logic [3:0] ALU_CC_GE    = 4'd5;
  localparam logic [3:0] ALU_CC_TSTZ  = 4'd6;
  localparam logic [3:0] ALU_CC_TSTNZ = 4'd7;

  // Accept-to-result latency: magnitude setup, restoring iterations, sign fix.
  localparam int unsigned DIV_LATENCY = 34;
  localparam int unsigned DIV_ITERS   = DIV_LATENCY - 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_DIV
  } exec_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU for all non-divide operations; DIV/MOD and unknown codes yield 0.
module alu
  import alu_exec_stage_pkg::*;
(
  input  logic [3:0]  op,
  input  logic        iscmp,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    if (iscmp) begin
      case (op)
        ALU_CC_EQ:    result = {31'd0, d0 == d1};
        ALU_CC_NE:    result = {31'd0, d0 != d1};
        ALU_CC_L:     result = {31'd0, $signed(d0) <  $signed(d1)};
        ALU_CC_LE:    result = {31'd0, $signed(d0) <= $signed(d1)};
        ALU_CC_G:     result = {31'd0, $signed(d0) >  $signed(d1)};
        ALU_CC_GE:    result = {31'd0, $signed(d0) >= $signed(d1)};
        ALU_CC_TSTZ:  result = {31'd0, (d0 & d1) == '0};
        ALU_CC_TSTNZ: result = {31'd0, (d0 & d1) != '0};
        default:      result = '0;
      endcase
    end else begin
      case (op)
        ALU_OP_ADD: result = d0 + d1;
        ALU_OP_SUB: result = d0 - d1;
        ALU_OP_MUL: result = d0 * d1;
        ALU_OP_OR:  result = d0 | d1;
        ALU_OP_XOR: result = d0 ^ d1;
        ALU_OP_AND: result = d0 & d1;
        // Shift count is the full unsigned d1; >= 32 saturates.
        ALU_OP_SHL: result = (d1 >= 32'd32) ? '0 : d0 << d1[4:0];
        ALU_OP_SAR: result = (d1 >= 32'd32) ? {32{d0[31]}}
                                            : 32'($signed(d0) >>> d1[4:0]);
        default:    result = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_stage_seq_divider.sv
// Iterative signed restoring divider: magnitudes latched on start, one quotient
// bit per cycle, sign fix applied combinationally while done is high.
module seq_divider
  import alu_exec_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        running;
  logic [5:0]  cnt;
  logic [31:0] rem, quo, dvs;
  logic        neg_q, neg_r;
  logic [32:0] rem_sh, diff;

  always_comb begin
    rem_sh    = {rem, quo[31]};
    diff      = rem_sh - {1'b0, dvs};
    done      = running && (cnt == 6'(DIV_ITERS));
    quotient  = neg_q ? -quo : quo;
    remainder = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      rem     <= '0;
      quo     <= abs32(d0);
      dvs     <= abs32(d1);
      neg_q   <= d0[31] ^ d1[31];
      neg_r   <= d0[31];
    end else if (running) begin
      if (cnt != 6'(DIV_ITERS)) begin
        cnt <= cnt + 6'd1;
        if (!diff[32]) begin
          rem <= diff[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= rem_sh[31:0];
          quo <= {quo[30:0], 1'b0};
        end
      end else begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: single-cycle ALU ops, iterative DIV/MOD, valid/ready
// handshakes on both sides, synchronous abort flush.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic                  in_iscmp,
  input  logic [31:0]           in_d0,
  input  logic [31:0]           in_d1,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  busy
);

  exec_state_e           state;
  logic                  accept, div_op, start_div, div_done, pend_mod;
  logic [REG_ADDR_W-1:0] pend_rd;
  logic [31:0]           alu_result, quick_result, div_q, div_r;

  alu u_alu (
    .op     (in_op),
    .iscmp  (in_iscmp),
    .d0     (in_d0),
    .d1     (in_d1),
    .result (alu_result)
  );

  seq_divider u_div (
    .clk       (clk),
    .rst       (reset),
    .start     (start_div),
    .abort     (abort),
    .d0        (in_d0),
    .d1        (in_d1),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    in_ready  = !reset && !abort &&
                (state == ST_IDLE || (state == ST_HOLD && out_ready));
    accept    = in_valid && in_ready;
    div_op    = !in_iscmp && (in_op == ALU_OP_DIV || in_op == ALU_OP_MOD);
    start_div = accept && div_op && (in_d1 != '0);
    // Divide by zero never enters the divider; its fixed result is immediate.
    quick_result = alu_result;
    if (div_op)
      quick_result = (in_op == ALU_OP_DIV) ? '1 : in_d0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      busy      <= 1'b0;
      pend_rd   <= '0;
      pend_mod  <= 1'b0;
    end else if (abort) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept && start_div) begin
            state     <= ST_DIV;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            pend_rd   <= in_rd;
            pend_mod  <= (in_op == ALU_OP_MOD);
          end else if (accept) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            out_data  <= quick_result;
            out_rd    <= in_rd;
          end else if (state == ST_HOLD && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state     <= ST_HOLD;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= pend_mod ? div_r : div_q;
            out_rd    <= pend_rd;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with hand-computed expected results.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  localparam int unsigned RW = 6;

  logic          clk = 1'b0;
  logic          reset, abort, in_valid, in_iscmp, out_ready;
  logic          in_ready, out_valid, busy;
  logic [3:0]    in_op;
  logic [31:0]   in_d0, in_d1, out_data;
  logic [RW-1:0] in_rd, out_rd;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic        cmp;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  alu_exec_stage #(.REG_ADDR_W(RW)) dut (
    .clk       (clk),
    .reset     (reset),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_iscmp  (in_iscmp),
    .in_d0     (in_d0),
    .in_d1     (in_d1),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .busy      (busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic cmp, input logic [31:0] a,
                       input logic [31:0] b, input logic [RW-1:0] rd);
    in_valid = 1'b1;
    in_op    = op;
    in_iscmp = cmp;
    in_d0    = a;
    in_d1    = b;
    in_rd    = rd;
  endtask

  task automatic drain;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_reset;
    reset = 1'b1; abort = 1'b0; in_valid = 1'b0; in_iscmp = 1'b0; out_ready = 1'b1;
    in_op = '0; in_d0 = '0; in_d1 = '0; in_rd = '0;
    repeat (2) step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%b busy=%b, required 0 0", out_valid, busy);
    end
    checks++;
    if (out_data !== 32'd0 || out_rd !== '0) begin
      errors++;
      $display("FAIL reset_data: out_data=%h out_rd=%0d, required 0 0", out_data, out_rd);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 0", in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_alu_back_to_back;
    vec_t v[12];
    v[0]  = '{ALU_OP_ADD,   1'b0, 32'd3,         32'd7,         32'd10,        1};
    v[1]  = '{ALU_OP_SHL,   1'b0, 32'd3,         32'd7,         32'd384,       1};
    v[2]  = '{ALU_OP_SAR,   1'b0, 32'hFFFFFC00,  32'd8,         32'hFFFFFFFC,  1};
    v[3]  = '{ALU_CC_L,     1'b1, 32'hFFFFFFFF,  32'd1,         32'd1,         1};
    v[4]  = '{ALU_CC_TSTZ,  1'b1, 32'd4,         32'd3,         32'd1,         1};
    v[5]  = '{ALU_CC_G,     1'b1, 32'd5,         32'd5,         32'd0,         1};
    v[6]  = '{ALU_OP_SUB,   1'b0, 32'd5,         32'd9,         32'hFFFFFFFC,  1};
    v[7]  = '{ALU_OP_MUL,   1'b0, 32'h00010000,  32'h00010001,  32'h00010000,  1};
    v[8]  = '{ALU_OP_SHL,   1'b0, 32'd1,         32'd32,        32'd0,         1};
    v[9]  = '{ALU_OP_SAR,   1'b0, 32'h80000000,  32'hFFFFFFFF,  32'hFFFFFFFF,  1};
    v[10] = '{ALU_OP_XOR,   1'b0, 32'h0000F0F0,  32'h0000FF00,  32'h00000FF0,  1};
    v[11] = '{4'hF,         1'b0, 32'd12,        32'd34,        32'd0,         1};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(v[i].op, v[i].cmp, v[i].a, v[i].b, RW'(i + 5));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL alu_in_ready[%0d]: got %b, required 1", i, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== v[i].exp || out_rd !== RW'(i + 5)) begin
        errors++;
        $display("FAIL alu_result[%0d]: valid=%b data=%h rd=%0d, required 1 %h %0d",
                 i, out_valid, out_data, out_rd, v[i].exp, i + 5);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL alu_consumed: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_div;
    vec_t v[7];
    int   n;
    v[0] = '{ALU_OP_DIV, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    v[1] = '{ALU_OP_MOD, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    v[2] = '{ALU_OP_DIV, 1'b0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    v[3] = '{ALU_OP_DIV, 1'b0, 32'd100,      32'd0,        32'hFFFFFFFF, 1};
    v[4] = '{ALU_OP_MOD, 1'b0, 32'd100,      32'd0,        32'd100,      1};
    v[5] = '{ALU_OP_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
    v[6] = '{ALU_OP_MOD, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(v[i].op, v[i].cmp, v[i].a, v[i].b, RW'(i + 20));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL div_in_ready[%0d]: got %b, required 1", i, in_ready);
      end
      step();
      in_valid = 1'b0;
      #1;
      n = 1;
      while (out_valid !== 1'b1 && n < 40) begin
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL div_busy[%0d] cycle %0d: busy=%b in_ready=%b, required 1 0",
                   i, n, busy, in_ready);
        end
        step();
        n++;
      end
      checks++;
      if (out_valid !== 1'b1 || n != v[i].lat) begin
        errors++;
        $display("FAIL div_latency[%0d]: valid=%b after %0d cycles, required 1 after %0d",
                 i, out_valid, n, v[i].lat);
      end
      checks++;
      if (out_data !== v[i].exp || out_rd !== RW'(i + 20) || busy !== 1'b0) begin
        errors++;
        $display("FAIL div_result[%0d]: data=%h rd=%0d busy=%b, required %h %0d 0",
                 i, out_data, out_rd, busy, v[i].exp, i + 20);
      end
    end
    drain();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(ALU_OP_ADD, 1'b0, 32'd1, 32'd2, RW'(3));
    step();
    drive(ALU_OP_XOR, 1'b0, 32'h000000F0, 32'h000000FF, RW'(4));
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd3 || out_rd !== RW'(3) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h rd=%0d in_ready=%b, required 1 3 3 0",
                 k, out_valid, out_data, out_rd, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000000F || out_rd !== RW'(4)) begin
      errors++;
      $display("FAIL bp_next: valid=%b data=%h rd=%0d, required 1 0000000f 4",
               out_valid, out_data, out_rd);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_consumed: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_abort;
    logic seen;
    out_ready = 1'b1;
    drive(ALU_OP_DIV, 1'b0, 32'd1000, 32'd3, RW'(2));
    step();
    in_valid = 1'b0;
    repeat (9) step();
    abort = 1'b1;
    drive(ALU_OP_ADD, 1'b0, 32'd1, 32'd1, RW'(1));
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_ready: got %b, required 0", in_ready);
    end
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: valid=%b busy=%b in_ready=%b, required 0 0 1",
               out_valid, busy, in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      step();
      if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_late_result: activity seen=%b, required 0", seen);
    end
  endtask

  task automatic test_reset_mid_div;
    logic seen;
    out_ready = 1'b1;
    drive(ALU_OP_DIV, 1'b0, 32'd1000, 32'd3, RW'(9));
    step();
    in_valid = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 || out_rd !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_div: busy=%b valid=%b data=%h rd=%0d in_ready=%b, required 0 0 0 0 0",
               busy, out_valid, out_data, out_rd, in_ready);
    end
    #1;
    reset = 1'b0;
    drive(ALU_OP_ADD, 1'b0, 32'd1, 32'd1, RW'(1));
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd2 || out_rd !== RW'(1)) begin
      errors++;
      $display("FAIL post_reset_add: valid=%b data=%h rd=%0d, required 1 2 1",
               out_valid, out_data, out_rd);
    end
    seen = 1'b0;
    repeat (40) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_late_result: out_valid seen=%b, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_div();
    test_backpressure();
    test_abort();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
